// File: rtl/div_16bit_seq_pkg.sv
// Shared definitions for the sequential divider: state encodings, the
// divide-by-zero quotient and two's-complement helpers.
package div_16bit_seq_pkg;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StCalc = 2'b01;
  localparam logic [1:0] StFix  = 2'b10;
  localparam logic [1:0] StZero = 2'b11;

  localparam logic [15:0] DivZeroQuot = 16'hFFFF;

  // Invert plus carry-in one.
  function automatic logic [15:0] neg16(input logic [15:0] x);
    return ~x + 16'd1;
  endfunction

  // |0x8000| stays 0x8000, which is the correct unsigned magnitude.
  function automatic logic [15:0] mag16(input logic [15:0] x, input logic is_signed);
    return (is_signed && x[15]) ? neg16(x) : x;
  endfunction

endpackage

// File: rtl/div_step_16bit.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude and keep the difference when it is non-negative.
module div_step_16bit (
  input  logic [15:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [15:0] dvs_i,
  output logic [15:0] rem_o,
  output logic        q_bit_o
);

  logic [16:0] shifted;
  logic [16:0] diff;

  // rem_i < dvs_i, so the shifted value fits in 17 bits and bit 16 of the
  // difference is a reliable borrow.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_bit_o = ~diff[16];
    rem_o   = q_bit_o ? diff[15:0] : shifted[15:0];
  end

endmodule

// File: rtl/div_16bit_seq.sv
// Multicycle 16-bit signed/unsigned divider, one quotient bit per cycle,
// with sign correction in a final FIX cycle and a fast divide-by-zero path.
module div_16bit_seq
  import div_16bit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             SignedOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             DivZero
);

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  div_step_16bit u_step (
    .rem_i     (prem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (B == '0) begin
            // dvd_q carries the raw dividend through to ZERO.
            dvd_d   = A;
            state_d = StZero;
          end else begin
            dvd_d      = mag16(A, SignedOp);
            dvs_d      = mag16(B, SignedOp);
            prem_d     = '0;
            cnt_d      = '0;
            neg_quot_d = SignedOp & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_d  = SignedOp & A[WIDTH-1];
            state_d    = StCalc;
          end
        end
      end
      StCalc: begin
        // Quotient bits fill dvd_q from the bottom as dividend bits leave the top.
        prem_d = step_rem;
        dvd_d  = {dvd_q[WIDTH-2:0], step_q_bit};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quot_d     = neg_quot_q ? neg16(dvd_q) : dvd_q;
        rem_d      = neg_rem_q ? neg16(prem_q) : prem_q;
        div_zero_d = 1'b0;
        done_d     = 1'b1;
        cnt_d      = '0;
        state_d    = StIdle;
      end
      default: begin
        quot_d     = DivZeroQuot;
        rem_d      = dvd_q;
        div_zero_d = 1'b1;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign Quot    = quot_q;
  assign Rem     = rem_q;
  assign DivZero = div_zero_q;

endmodule

// File: tb/tb_div_16bit_seq.sv
// Directed bench for div_16bit_seq: hand-computed quotients, remainders and
// latencies, checked with immediate assertions on the falling edge.
module tb_div_16bit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        SignedOp;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Quot;
  logic [15:0] Rem;
  logic        DivZero;

  int vectors;
  int miscompares;
  int lat;
  int done_cnt;

  div_16bit_seq #(
    .WIDTH (16),
    .ITER  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .SignedOp (SignedOp),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Quot     (Quot),
    .Rem      (Rem),
    .DivZero  (DivZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge where done is seen.
  // lat counts falling edges from the start cycle, so a normal op gives 18.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input bit repulse, output int lat_o);
    SignedOp = s;
    A        = a;
    B        = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    A        = ~a;
    B        = 16'h5A5A;
    SignedOp = ~s;
    lat_o    = 1;
    check("busy after start", {15'd0, busy}, 16'd1);
    while (!done && lat_o < 40) begin
      if (repulse && lat_o == 5) begin
        start    = 1'b1;
        A        = 16'd9;
        B        = 16'd2;
        SignedOp = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat_o++;
    end
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    SignedOp    = 1'b0;
    A           = '0;
    B           = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", {15'd0, busy}, 16'd0);
    check("reset done", {15'd0, done}, 16'd0);
    check("reset quot", Quot, 16'd0);
    check("reset rem", Rem, 16'd0);
    check("reset divzero", {15'd0, DivZero}, 16'd0);

    run_op(1'b0, 16'd100, 16'd7, 1'b0, lat);
    check("u100/7 latency", 16'(lat), 16'd18);
    check("u100/7 quot", Quot, 16'd14);
    check("u100/7 rem", Rem, 16'd2);
    check("u100/7 divzero", {15'd0, DivZero}, 16'd0);
    check("u100/7 busy at done", {15'd0, busy}, 16'd0);
    @(negedge clk);
    check("u100/7 done width", {15'd0, done}, 16'd0);

    run_op(1'b1, 16'hFF9C, 16'd7, 1'b0, lat);
    check("s-100/7 quot", Quot, 16'hFFF2);
    check("s-100/7 rem", Rem, 16'hFFFE);
    @(negedge clk);

    run_op(1'b1, 16'd100, 16'hFFF9, 1'b0, lat);
    check("s100/-7 quot", Quot, 16'hFFF2);
    check("s100/-7 rem", Rem, 16'd2);
    @(negedge clk);

    run_op(1'b0, 16'd1234, 16'd0, 1'b0, lat);
    check("div0 latency", 16'(lat), 16'd2);
    check("div0 quot", Quot, 16'hFFFF);
    check("div0 rem", Rem, 16'd1234);
    check("div0 divzero", {15'd0, DivZero}, 16'd1);
    @(negedge clk);
    check("div0 done width", {15'd0, done}, 16'd0);

    run_op(1'b1, 16'd50, 16'd5, 1'b0, lat);
    check("after div0 quot", Quot, 16'd10);
    check("after div0 rem", Rem, 16'd0);
    check("after div0 divzero", {15'd0, DivZero}, 16'd0);
    @(negedge clk);

    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0, lat);
    check("s overflow quot", Quot, 16'h8000);
    check("s overflow rem", Rem, 16'd0);
    @(negedge clk);

    run_op(1'b0, 16'hFFFF, 16'd1, 1'b0, lat);
    check("uFFFF/1 quot", Quot, 16'hFFFF);
    check("uFFFF/1 rem", Rem, 16'd0);
    @(negedge clk);

    // Second start mid-operation must not disturb the first result.
    run_op(1'b0, 16'd1000, 16'd3, 1'b1, lat);
    check("repulse latency", 16'(lat), 16'd18);
    check("repulse quot", Quot, 16'd333);
    check("repulse rem", Rem, 16'd1);

    // Start issued in the done cycle is accepted.
    run_op(1'b0, 16'd77, 16'd4, 1'b0, lat);
    check("b2b latency", 16'(lat), 16'd18);
    check("b2b quot", Quot, 16'd19);
    check("b2b rem", Rem, 16'd1);
    @(negedge clk);
    check("b2b done width", {15'd0, done}, 16'd0);

    // Reset during CALC aborts at once.
    SignedOp = 1'b0;
    A        = 16'd1000;
    B        = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {15'd0, busy}, 16'd0);
    check("abort done", {15'd0, done}, 16'd0);
    check("abort quot", Quot, 16'd0);
    check("abort rem", Rem, 16'd0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", 16'(done_cnt), 16'd0);
    check("abort idle", {15'd0, busy}, 16'd0);

    run_op(1'b0, 16'd200, 16'd9, 1'b0, lat);
    check("post-abort latency", 16'(lat), 16'd18);
    check("post-abort quot", Quot, 16'd22);
    check("post-abort rem", Rem, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
